// File: rtl/axi_master_bridge_pkg.sv
// Shared definitions for the AXI master bridge.
// Contents:
//   - read and write FSM state encodings
//   - fixed AXI4 burst attributes (single 8-byte INCR beat)
//   - response code helper
//   - requester id tags used by the cache/uncache arbiter
package axi_master_bridge_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2,
    R_DONE = 2'd3
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_RESP = 2'd2,
    W_DONE = 2'd3
  } wr_state_e;

  localparam logic [2:0] SIZE_8B    = 3'b011;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [7:0] LEN_SINGLE = 8'd0;

  localparam int ID_ICACHE  = 0;
  localparam int ID_DCACHE  = 1;
  localparam int ID_UNCACHE = 2;

  // Any response other than OKAY (EXOKAY, SLVERR, DECERR) counts as a bus error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_master_wr_ch.sv
// Write channel of the AXI master bridge.
// Accepts a level-held write request, issues one single-beat AW+W pair,
// waits for the B response and pulses w_refresh_o once.
// Ports:
//   clk, rst                       clock, async active-high reset
//   aw_e_i/aw_addr_i/w_data_i/w_mask_i   write request from the arbiter
//   w_refresh_o                    one-cycle write-complete pulse
//   wr_err_o                       single-cycle flag: non-OKAY BRESP accepted
//   axi_aw*/axi_w*/axi_b*          AXI4 write address, data and response channels
module axi_master_wr_ch
  import axi_master_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                aw_e_i,
  input  logic [ADDR_W-1:0]   aw_addr_i,
  input  logic [DATA_W-1:0]   w_data_i,
  input  logic [DATA_W/8-1:0] w_mask_i,
  output logic                w_refresh_o,
  output logic                wr_err_o,
  output logic                axi_awvalid,
  input  logic                axi_awready,
  output logic [ADDR_W-1:0]   axi_awaddr,
  output logic [ID_W-1:0]     axi_awid,
  output logic [7:0]          axi_awlen,
  output logic [2:0]          axi_awsize,
  output logic [1:0]          axi_awburst,
  output logic                axi_wvalid,
  input  logic                axi_wready,
  output logic [DATA_W-1:0]   axi_wdata,
  output logic [DATA_W/8-1:0] axi_wstrb,
  output logic                axi_wlast,
  input  logic                axi_bvalid,
  output logic                axi_bready,
  input  logic [1:0]          axi_bresp
);

  wr_state_e             state_q, state_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [DATA_W/8-1:0]   mask_q, mask_d;

  // Each valid is held from W_REQ entry until its own handshake; the done
  // flags are registered so neither valid looks at a ready combinationally.
  assign axi_awvalid = (state_q == W_REQ) && !aw_done_q;
  assign axi_wvalid  = (state_q == W_REQ) && !w_done_q;
  assign axi_wlast   = axi_wvalid;
  assign axi_bready  = (state_q == W_RESP);
  assign w_refresh_o = (state_q == W_DONE);

  assign axi_awaddr  = addr_q;
  assign axi_wdata   = data_q;
  assign axi_wstrb   = mask_q;
  // Writes carry no requester tag, so the AXI id is fixed at zero.
  assign axi_awid    = '0;
  assign axi_awlen   = LEN_SINGLE;
  assign axi_awsize  = SIZE_8B;
  assign axi_awburst = BURST_INCR;

  // Next-state logic: AW and W complete in any order, RESP once both are done.
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    addr_d    = addr_q;
    data_d    = data_q;
    mask_d    = mask_q;
    wr_err_o  = 1'b0;
    case (state_q)
      W_IDLE: begin
        if (aw_e_i) begin
          addr_d    = aw_addr_i;
          data_d    = w_data_i;
          mask_d    = w_mask_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = W_REQ;
        end
      end
      W_REQ: begin
        aw_done_d = aw_done_q | (axi_awvalid & axi_awready);
        w_done_d  = w_done_q | (axi_wvalid & axi_wready);
        if (aw_done_d && w_done_d) begin
          state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (axi_bvalid) begin
          wr_err_o = resp_is_err(axi_bresp);
          state_d  = W_DONE;
        end
      end
      W_DONE:  state_d = W_IDLE;
      default: state_d = W_IDLE;
    endcase
  end

  // State and captured request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= W_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      mask_q    <= '0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      mask_q    <= mask_d;
    end
  end

endmodule

// File: rtl/axi_master_bridge.sv
// AXI master bridge: turns the arbiter's level-held read/write requests into
// single-beat 64-bit AXI4 transactions. Read and write run independently.
// Ports:
//   clk, rst                          clock, async active-high reset
//   ar_e_i/ar_id_i/ar_addr_i          read request; r_data_o/r_id_o/r_refresh_o reply
//   aw_e_i/aw_addr_i/w_data_i/w_mask_i write request; w_refresh_o reply
//   bus_err_o                         sticky flag for any non-OKAY RRESP/BRESP
//   axi_*                             AXI4 master interface
module axi_master_bridge
  import axi_master_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ar_e_i,
  input  logic [ID_W-1:0]     ar_id_i,
  input  logic [ADDR_W-1:0]   ar_addr_i,
  output logic [DATA_W-1:0]   r_data_o,
  output logic [ID_W-1:0]     r_id_o,
  output logic                r_refresh_o,
  input  logic                aw_e_i,
  input  logic [ADDR_W-1:0]   aw_addr_i,
  input  logic [DATA_W-1:0]   w_data_i,
  input  logic [DATA_W/8-1:0] w_mask_i,
  output logic                w_refresh_o,
  output logic                bus_err_o,
  output logic                axi_arvalid,
  input  logic                axi_arready,
  output logic [ADDR_W-1:0]   axi_araddr,
  output logic [ID_W-1:0]     axi_arid,
  output logic [7:0]          axi_arlen,
  output logic [2:0]          axi_arsize,
  output logic [1:0]          axi_arburst,
  input  logic                axi_rvalid,
  output logic                axi_rready,
  input  logic [DATA_W-1:0]   axi_rdata,
  input  logic [1:0]          axi_rresp,
  input  logic                axi_rlast,
  output logic                axi_awvalid,
  input  logic                axi_awready,
  output logic [ADDR_W-1:0]   axi_awaddr,
  output logic [ID_W-1:0]     axi_awid,
  output logic [7:0]          axi_awlen,
  output logic [2:0]          axi_awsize,
  output logic [1:0]          axi_awburst,
  output logic                axi_wvalid,
  input  logic                axi_wready,
  output logic [DATA_W-1:0]   axi_wdata,
  output logic [DATA_W/8-1:0] axi_wstrb,
  output logic                axi_wlast,
  input  logic                axi_bvalid,
  output logic                axi_bready,
  input  logic [1:0]          axi_bresp
);

  rd_state_e           rd_state_q, rd_state_d;
  logic [ADDR_W-1:0]   ar_addr_q, ar_addr_d;
  logic [ID_W-1:0]     ar_id_q, ar_id_d;
  logic [DATA_W-1:0]   r_data_q, r_data_d;
  logic                bus_err_q, bus_err_d;
  logic                rd_err;
  logic                wr_err;

  // Every read is a single beat, so RLAST always accompanies the only beat
  // and carries no extra information.
  logic unused_rlast;
  assign unused_rlast = axi_rlast;

  assign axi_arvalid = (rd_state_q == R_ADDR);
  assign axi_rready  = (rd_state_q == R_DATA);
  assign r_refresh_o = (rd_state_q == R_DONE);
  assign axi_araddr  = ar_addr_q;
  assign axi_arid    = ar_id_q;
  assign axi_arlen   = LEN_SINGLE;
  assign axi_arsize  = SIZE_8B;
  assign axi_arburst = BURST_INCR;
  assign r_data_o    = r_data_q;
  // RID from the interconnect is ignored; only one read is ever outstanding.
  assign r_id_o      = ar_id_q;
  assign bus_err_o   = bus_err_q;

  // Read FSM next-state: request is latched in IDLE and then ignored until done.
  always_comb begin
    rd_state_d = rd_state_q;
    ar_addr_d  = ar_addr_q;
    ar_id_d    = ar_id_q;
    r_data_d   = r_data_q;
    rd_err     = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        if (ar_e_i) begin
          ar_addr_d  = ar_addr_i;
          ar_id_d    = ar_id_i;
          rd_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        if (axi_arready) rd_state_d = R_DATA;
      end
      R_DATA: begin
        if (axi_rvalid) begin
          r_data_d   = axi_rdata;
          rd_err     = resp_is_err(axi_rresp);
          rd_state_d = R_DONE;
        end
      end
      R_DONE:  rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Error flag is sticky; only reset clears it.
  always_comb begin
    bus_err_d = bus_err_q | rd_err | wr_err;
  end

  // Read-side and error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_q <= R_IDLE;
      ar_addr_q  <= '0;
      ar_id_q    <= '0;
      r_data_q   <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      ar_addr_q  <= ar_addr_d;
      ar_id_q    <= ar_id_d;
      r_data_q   <= r_data_d;
      bus_err_q  <= bus_err_d;
    end
  end

  axi_master_wr_ch #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .ID_W   (ID_W)
  ) u_wr_ch (
    .clk         (clk),
    .rst         (rst),
    .aw_e_i      (aw_e_i),
    .aw_addr_i   (aw_addr_i),
    .w_data_i    (w_data_i),
    .w_mask_i    (w_mask_i),
    .w_refresh_o (w_refresh_o),
    .wr_err_o    (wr_err),
    .axi_awvalid (axi_awvalid),
    .axi_awready (axi_awready),
    .axi_awaddr  (axi_awaddr),
    .axi_awid    (axi_awid),
    .axi_awlen   (axi_awlen),
    .axi_awsize  (axi_awsize),
    .axi_awburst (axi_awburst),
    .axi_wvalid  (axi_wvalid),
    .axi_wready  (axi_wready),
    .axi_wdata   (axi_wdata),
    .axi_wstrb   (axi_wstrb),
    .axi_wlast   (axi_wlast),
    .axi_bvalid  (axi_bvalid),
    .axi_bready  (axi_bready),
    .axi_bresp   (axi_bresp)
  );

endmodule

// File: tb/tb_axi_master_bridge.sv
// Bench for axi_master_bridge: a requester driving read/write requests from a
// vector table, plus a behavioural AXI slave with per-request wait states.
module tb_axi_master_bridge;
  import axi_master_bridge_pkg::*;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 4;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ar_e_i = 1'b0;
  logic [IW-1:0] ar_id_i = '0;
  logic [AW-1:0] ar_addr_i = '0;
  logic [DW-1:0] r_data_o;
  logic [IW-1:0] r_id_o;
  logic          r_refresh_o;
  logic          aw_e_i = 1'b0;
  logic [AW-1:0] aw_addr_i = '0;
  logic [DW-1:0] w_data_i = '0;
  logic [SW-1:0] w_mask_i = '0;
  logic          w_refresh_o;
  logic          bus_err_o;
  logic          axi_arvalid;
  logic          axi_arready = 1'b0;
  logic [AW-1:0] axi_araddr;
  logic [IW-1:0] axi_arid;
  logic [7:0]    axi_arlen;
  logic [2:0]    axi_arsize;
  logic [1:0]    axi_arburst;
  logic          axi_rvalid = 1'b0;
  logic          axi_rready;
  logic [DW-1:0] axi_rdata = '0;
  logic [1:0]    axi_rresp = '0;
  logic          axi_rlast = 1'b0;
  logic          axi_awvalid;
  logic          axi_awready = 1'b0;
  logic [AW-1:0] axi_awaddr;
  logic [IW-1:0] axi_awid;
  logic [7:0]    axi_awlen;
  logic [2:0]    axi_awsize;
  logic [1:0]    axi_awburst;
  logic          axi_wvalid;
  logic          axi_wready = 1'b0;
  logic [DW-1:0] axi_wdata;
  logic [SW-1:0] axi_wstrb;
  logic          axi_wlast;
  logic          axi_bvalid = 1'b0;
  logic          axi_bready;
  logic [1:0]    axi_bresp = '0;

  typedef struct {
    bit            isWrite;
    logic [AW-1:0] addr;
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [SW-1:0] mask;
    int            waitA;
    int            waitB;
    int            waitC;
    logic [1:0]    resp;
    int            expLat;
    logic          expErr;
  } vec_t;

  vec_t rdExpQ[$];
  vec_t wrExpQ[$];
  vec_t tbl[0:5];

  int total = 0;
  int bad = 0;
  int rdDone = 0, wrDone = 0, rdPulses = 0, wrPulses = 0;
  int rdViol = 0, wrViol = 0;

  // Slave behaviour knobs, set per request
  int            arWait = 0, rWait = 0, awWait = 0, wWait = 0, bWait = 0;
  logic [1:0]    rrespCur = '0, brespCur = '0;
  logic [DW-1:0] rdDataCur = '0;

  // Slave-side captured request fields
  logic [AW-1:0] rdCapAddr = '0, arFirst = '0;
  logic [AW-1:0] capAwAddr = '0;
  logic [DW-1:0] capWData = '0;
  logic [SW-1:0] capWStrb = '0;

  axi_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .clk(clk), .rst(rst),
    .ar_e_i(ar_e_i), .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i),
    .r_data_o(r_data_o), .r_id_o(r_id_o), .r_refresh_o(r_refresh_o),
    .aw_e_i(aw_e_i), .aw_addr_i(aw_addr_i), .w_data_i(w_data_i), .w_mask_i(w_mask_i),
    .w_refresh_o(w_refresh_o), .bus_err_o(bus_err_o),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
    .axi_arid(axi_arid), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
    .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
    .axi_awid(axi_awid), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
    .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp)
  );

  always #5 clk = ~clk;

  // Count refresh pulses so a doubled or missing pulse shows up at the end.
  always @(negedge clk) begin
    if (r_refresh_o) rdPulses++;
    if (w_refresh_o) wrPulses++;
  end

  // Read slave: arready after arWait cycles of arvalid, rvalid rWait cycles later.
  int rs = 0, rcnt = 0;
  bit rpend = 0;
  always @(negedge clk) begin
    if (rst) begin
      rs = 0; rcnt = 0; rpend = 0;
      axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rlast = 1'b0;
    end else begin
      case (rs)
        0: if (axi_arvalid) begin
          if (rcnt == 0) arFirst = axi_araddr;
          else if (axi_araddr !== arFirst) rdViol++;
          if (rcnt == arWait) begin
            axi_arready = 1'b1;
            rdCapAddr = axi_araddr;
            if (axi_arlen !== 8'd0 || axi_arsize !== 3'b011 || axi_arburst !== 2'b01) rdViol++;
            rs = 1; rcnt = 0;
          end else rcnt++;
        end
        1: begin
          axi_arready = 1'b0;
          if (axi_arvalid) rdViol++;
          if (rcnt == rWait) begin
            axi_rvalid = 1'b1; axi_rlast = 1'b1;
            axi_rdata = rdDataCur; axi_rresp = rrespCur;
            rpend = axi_rready;
            rs = 2;
          end else rcnt++;
        end
        default: begin
          if (rpend) begin
            axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rdata = '0; axi_rresp = '0;
            rs = 0; rcnt = 0;
          end else rpend = axi_rready;
        end
      endcase
    end
  end

  // Write slave: AW and W accepted independently, B once both are in.
  int awcnt = 0, wcnt = 0, bcnt = 0;
  bit awGot = 0, wGot = 0, bpend = 0;
  always @(negedge clk) begin
    if (rst) begin
      awcnt = 0; wcnt = 0; bcnt = 0; awGot = 0; wGot = 0; bpend = 0;
      axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0;
    end else begin
      if (axi_awready) begin
        axi_awready = 1'b0; awGot = 1;
      end else if (!awGot && axi_awvalid) begin
        if (awcnt == awWait) begin
          axi_awready = 1'b1; capAwAddr = axi_awaddr;
          if (axi_awlen !== 8'd0 || axi_awsize !== 3'b011 || axi_awburst !== 2'b01) wrViol++;
        end else awcnt++;
      end
      if (axi_wready) begin
        axi_wready = 1'b0; wGot = 1;
      end else if (!wGot && axi_wvalid) begin
        if (wcnt == wWait) begin
          axi_wready = 1'b1; capWData = axi_wdata; capWStrb = axi_wstrb;
        end else wcnt++;
      end
      if (awGot && axi_awvalid) wrViol++;
      if (wGot && axi_wvalid) wrViol++;
      if (axi_wvalid && !axi_wlast) wrViol++;
      if (axi_bready && !(awGot && wGot)) wrViol++;
      if (axi_bvalid) begin
        if (bpend) begin
          axi_bvalid = 1'b0; axi_bresp = '0;
          awGot = 0; wGot = 0; awcnt = 0; wcnt = 0; bcnt = 0;
        end else bpend = axi_bready;
      end else if (awGot && wGot) begin
        if (bcnt == bWait) begin
          axi_bvalid = 1'b1; axi_bresp = brespCur; bpend = axi_bready;
        end else bcnt++;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mkRd(input logic [AW-1:0] a, input int id, input logic [DW-1:0] d,
                                input int arW, input int rW, input logic [1:0] resp,
                                input int lat, input logic err);
    vec_t v;
    v.isWrite = 0; v.addr = a; v.id = IW'(id); v.data = d; v.mask = '0;
    v.waitA = arW; v.waitB = rW; v.waitC = 0; v.resp = resp; v.expLat = lat; v.expErr = err;
    return v;
  endfunction

  function automatic vec_t mkWr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] m,
                                input int awW, input int wW, input int bW, input logic [1:0] resp,
                                input int lat, input logic err);
    vec_t v;
    v.isWrite = 1; v.addr = a; v.id = '0; v.data = d; v.mask = m;
    v.waitA = awW; v.waitB = wW; v.waitC = bW; v.resp = resp; v.expLat = lat; v.expErr = err;
    return v;
  endfunction

  // Issue one request, hold it until its refresh, then compare against the
  // scoreboard entry pushed when the request was driven.
  task automatic applyStimulus(input vec_t v);
    int cyc;
    bit seen;
    vec_t e;
    @(negedge clk);
    cyc = 0; seen = 0;
    if (!v.isWrite) begin
      arWait = v.waitA; rWait = v.waitB; rrespCur = v.resp; rdDataCur = v.data;
      rdExpQ.push_back(v);
      ar_e_i = 1'b1; ar_addr_i = v.addr; ar_id_i = v.id;
      while (!seen && cyc < 100) begin
        @(negedge clk); cyc++;
        if (cyc == 1) begin ar_addr_i = ~v.addr; ar_id_i = ~v.id; end
        if (r_refresh_o) seen = 1;
      end
      e = rdExpQ.pop_front();
      ar_e_i = 1'b0;
      if (!seen) checkOutput("rdTimeout", 64'd0, 64'd1);
      else begin
        rdDone++;
        checkOutput("rdAraddr", rdCapAddr, e.addr);
        checkOutput("rdData", r_data_o, e.data);
        checkOutput("rdId", r_id_o, e.id);
        checkOutput("rdLatency", cyc, e.expLat);
        checkOutput("rdBusErr", bus_err_o, e.expErr);
        @(negedge clk);
        checkOutput("rdPulseWidth", r_refresh_o, 0);
      end
    end else begin
      awWait = v.waitA; wWait = v.waitB; bWait = v.waitC; brespCur = v.resp;
      wrExpQ.push_back(v);
      aw_e_i = 1'b1; aw_addr_i = v.addr; w_data_i = v.data; w_mask_i = v.mask;
      while (!seen && cyc < 100) begin
        @(negedge clk); cyc++;
        if (cyc == 1) begin aw_addr_i = ~v.addr; w_data_i = ~v.data; w_mask_i = ~v.mask; end
        if (w_refresh_o) seen = 1;
      end
      e = wrExpQ.pop_front();
      aw_e_i = 1'b0;
      if (!seen) checkOutput("wrTimeout", 64'd0, 64'd1);
      else begin
        wrDone++;
        checkOutput("wrAwaddr", capAwAddr, e.addr);
        checkOutput("wrWdata", capWData, e.data);
        checkOutput("wrWstrb", capWStrb, e.mask);
        checkOutput("wrLatency", cyc, e.expLat);
        checkOutput("wrBusErr", bus_err_o, e.expErr);
        @(negedge clk);
        checkOutput("wrPulseWidth", w_refresh_o, 0);
      end
    end
  endtask

  // Main sequence: reset, table of single requests, then the multi-cycle corners.
  initial begin
    int cyc;
    // Latency = 3 + read wait states, or 3 + max(aw, w) + b wait states
    tbl[0] = mkRd(32'h8000_0010, ID_DCACHE, 64'hDEAD_BEEF_0123_4567, 0, 0, 2'b00, 3, 1'b0);
    tbl[1] = mkRd(32'h8000_0020, ID_UNCACHE, 64'h0123_4567_89AB_CDEF, 5, 0, 2'b00, 8, 1'b0);
    tbl[2] = mkRd(32'h0000_1FF8, ID_ICACHE, 64'hFFFF_0000_FFFF_0000, 1, 3, 2'b00, 7, 1'b0);
    tbl[3] = mkWr(32'h1000_0000, 64'h0000_0000_0000_00AA, 8'h01, 2, 0, 0, 2'b00, 5, 1'b0);
    tbl[4] = mkWr(32'h2000_0008, 64'h1122_3344_5566_7788, 8'hFF, 0, 3, 1, 2'b00, 7, 1'b0);
    tbl[5] = mkWr(32'h3000_0010, 64'hCAFE_F00D_0BAD_BEEF, 8'hF0, 1, 1, 0, 2'b00, 4, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("rstCtl", {axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready,
                           r_refresh_o, w_refresh_o, bus_err_o}, 8'h00);
    checkOutput("rstRdRegs", {r_data_o, r_id_o}, '0);
    checkOutput("rstAxiAddr", {axi_araddr, axi_awaddr}, '0);
    checkOutput("rstWrRegs", {axi_wdata, axi_wstrb}, '0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idleCtl", {axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready,
                            r_refresh_o, w_refresh_o, bus_err_o}, 8'h00);

    for (int i = 0; i < 6; i++) applyStimulus(tbl[i]);

    // Read and write launched in the same cycle
    fork
      applyStimulus(mkRd(32'h8000_1000, ID_ICACHE, 64'h0F0F_0F0F_0F0F_0F0F, 0, 0, 2'b00, 3, 1'b0));
      applyStimulus(mkWr(32'h9000_0000, 64'hF0F0_F0F0_F0F0_F0F0, 8'h3C, 0, 0, 0, 2'b00, 3, 1'b0));
    join

    // Error response on a read, then the flag must survive OKAY traffic
    applyStimulus(mkRd(32'h8000_2000, ID_DCACHE, 64'h0000_0000_DEAD_0001, 1, 1, 2'b10, 5, 1'b1));
    applyStimulus(mkRd(32'h8000_2008, ID_DCACHE, 64'h0000_0000_0000_0002, 0, 0, 2'b00, 3, 1'b1));
    applyStimulus(mkWr(32'h1000_0040, 64'h0000_0000_0000_0003, 8'h0F, 0, 0, 0, 2'b00, 3, 1'b1));

    // Reset while the read sits in R_DATA and the write in W_REQ
    @(negedge clk);
    arWait = 0; rWait = 30; rrespCur = 2'b00; rdDataCur = 64'h5555_5555_5555_5555;
    awWait = 0; wWait = 30; bWait = 0; brespCur = 2'b00;
    ar_e_i = 1'b1; ar_addr_i = 32'h4000_0000; ar_id_i = IW'(ID_UNCACHE);
    aw_e_i = 1'b1; aw_addr_i = 32'h5000_0000; w_data_i = 64'h1234; w_mask_i = 8'hFF;
    cyc = 0;
    while (!(axi_rready && axi_wvalid) && cyc < 50) begin @(negedge clk); cyc++; end
    checkOutput("rstMidReach", (cyc < 50), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rstMidCtl", {axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready,
                              r_refresh_o, w_refresh_o, bus_err_o}, 8'h00);
    checkOutput("rstMidRegs", {r_data_o, r_id_o}, '0);
    ar_e_i = 1'b0; aw_e_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    applyStimulus(mkRd(32'h8000_3000, ID_UNCACHE, 64'hA5A5_5A5A_A5A5_5A5A, 0, 0, 2'b00, 3, 1'b0));
    applyStimulus(mkWr(32'h1000_0080, 64'h0000_0000_0000_0004, 8'h80, 0, 0, 0, 2'b11, 3, 1'b1));

    repeat (2) @(negedge clk);
    checkOutput("rdPulseCount", rdPulses, rdDone);
    checkOutput("wrPulseCount", wrPulses, wrDone);
    checkOutput("rdProtocol", rdViol, 0);
    checkOutput("wrProtocol", wrViol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_master_bridge.md
Name: axi_master_bridge

Overview:
- Slave end of the cache/uncache arbiter's simple request interface, and AXI4 master toward the memory/peripheral interconnect.
- Converts level-held read requests (ar_e/ar_id/ar_addr) and write requests (aw_e/aw_addr/w_data/w_mask) into single-beat 64-bit AXI4 transactions.
- Returns read data with a one-cycle refresh pulse tagged by the request id, and a write-done pulse.
- Read and write channels run independently and may be in flight concurrently.

Parameters:
- ADDR_W, 32, request/AXI address width
- DATA_W, 64, data width; strobe width is DATA_W/8
- ID_W, 4, request id width; also driven on AXI arid/awid

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- ar_e_i  in  1  read request, level-held by the requester until r_refresh_o
- ar_id_i  in  ID_W  requester tag: 0 icache, 1 dcache, 2 uncache
- ar_addr_i  in  ADDR_W  read address
- r_data_o  out  DATA_W  read data, valid while r_refresh_o=1
- r_id_o  out  ID_W  tag of the returned read
- r_refresh_o  out  1  one-cycle read-complete pulse
- aw_e_i  in  1  write request, level-held until w_refresh_o
- aw_addr_i  in  ADDR_W  write address
- w_data_i  in  DATA_W  write data
- w_mask_i  in  DATA_W/8  byte strobes
- w_refresh_o  out  1  one-cycle write-complete pulse
- bus_err_o  out  1  sticky: any nonzero RRESP/BRESP
- axi_arvalid out 1 / axi_arready in 1 / axi_araddr out ADDR_W / axi_arid out ID_W
- axi_rvalid in 1 / axi_rready out 1 / axi_rdata in DATA_W / axi_rresp in 2 / axi_rlast in 1
- axi_awvalid out 1 / axi_awready in 1 / axi_awaddr out ADDR_W / axi_awid out ID_W
- axi_wvalid out 1 / axi_wready in 1 / axi_wdata out DATA_W / axi_wstrb out DATA_W/8 / axi_wlast out 1
- axi_bvalid in 1 / axi_bready out 1 / axi_bresp in 2
- axi_arlen, axi_awlen out 8: constant 0; axi_arsize, axi_awsize out 3: constant 3'b011; axi_arburst, axi_awburst out 2: constant 2'b01

Behaviour:
- Reset (async, rst=1): both FSMs go to IDLE. All valid, ready, refresh and bus_err outputs are 0. Captured address, data and id registers are 0. Reset mid-transaction abandons the transaction; this is legal only under whole-system reset.
- Read FSM R_IDLE→R_ADDR→R_DATA→R_DONE→R_IDLE:
  - R_IDLE: if ar_e_i=1, latch ar_addr_i and ar_id_i, go to R_ADDR.
  - R_ADDR: axi_arvalid=1 with the latched addr/id. It stays stable until axi_arready; then go to R_DATA.
  - R_DATA: axi_rready=1. On axi_rvalid, capture rdata into r_data_o, OR (rresp≠0) into bus_err_o, go to R_DONE. axi_rid is ignored; r_id_o is always the latched id.
  - R_DONE: r_refresh_o=1 for exactly one cycle, then go to R_IDLE.
- Write FSM W_IDLE→W_REQ→W_RESP→W_DONE→W_IDLE:
  - W_IDLE: if aw_e_i=1, latch addr, data and mask, go to W_REQ.
  - W_REQ: axi_awvalid and axi_wvalid both assert on entry. Each drops independently after its own handshake. The W handshake may precede, coincide with or follow AW. When both are done, go to W_RESP. axi_wlast=1 whenever axi_wvalid=1.
  - W_RESP: axi_bready=1. On axi_bvalid, OR (bresp≠0) into bus_err_o, go to W_DONE.
  - W_DONE: w_refresh_o=1 for one cycle, then go to W_IDLE.
- Valids must never depend combinationally on readies.
- Minimum read latency: request sampled in cycle 0; arvalid in cycle 1; rvalid accepted in cycle 2 at the earliest; r_refresh_o in cycle 3.
- Requesters deassert on the cycle after refresh. Because the FSM passes through DONE, a request held over into IDLE after refresh is a genuine new request.
- Simultaneous ar_e_i and aw_e_i: both launch in the same cycle. No ordering is enforced between channels; the arbiter serialises dependent accesses.
- Requests arriving while a channel is busy are ignored until that channel returns to IDLE. Input changes during busy states are not sampled.
- bus_err_o clears only on reset.

Decomposition:
- Shared package holds:
  - read and write FSM state encodings
  - AXI constants: SIZE_8B=3'b011, BURST_INCR=2'b01, RESP_OKAY=2'b00
  - requester id constants: ID_ICACHE=0, ID_DCACHE=1, ID_UNCACHE=2
- One natural sub-module, axi_master_wr_ch, holds the write FSM with its AW/W done flags. The read FSM stays in the top level.

Test Plan:
- ar_e_i=1, id=1, addr=0x8000_0010; slave gives arready at once, rvalid next cycle with data 0xDEAD_BEEF_0123_4567 → r_refresh_o pulses at cycle 3, r_id_o=1, r_data_o equals that data, arsize=3, arlen=0.
- arready held low 5 cycles → arvalid stays 1 and araddr stays stable throughout; exactly one refresh pulse follows.
- Write addr 0x1000_0000, data 0xAA, mask 0x01; wready 2 cycles before awready → each valid drops after its own handshake; bready=1 only after both; w_refresh_o pulses one cycle after bvalid; wstrb=0x01.
- Concurrent read (id 0) and write issued in the same cycle → both complete, each refresh fires exactly once, no cross-contamination of data or id.
- rresp=2'b10 on a read → read still completes with refresh; bus_err_o=1 and stays 1 through later OKAY transactions until rst.
- rst asserted while in R_DATA and W_REQ → all valids, readies and refreshes drop to 0 asynchronously; after release, a new read completes normally.
